uart_rx_ctrl: RTL

Parametrised UART receiver, successor to the single-mode receiver. Adds oversampled start detection with majority-vote sampling, configurable parity and stop bits, and per-character parity/framing error flags. Received characters are buffered in a small FIFO and delivered over a valid/ready stream interface. It sits between the board-level rx pin and any byte-stream consumer in the design.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_fifo.sv | 63 ++++++
 rtl/uart_rx_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package uart_pkg;

  localparam int MAX_DATA_WIDTH = 9;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH
  } rx_state_e;

  // One received character with its error flags; data is sized for the
  // widest legal character and narrower characters sit in the low bits.
  typedef struct packed {
    logic                      pe;
    logic                      fe;
    logic [MAX_DATA_WIDTH-1:0] data;
  } rx_entry_t;

  // Core clocks per oversample tick (integer division, truncating).
  function automatic int calc_tick_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received characters plus error flags.
// Latency: a pushed entry is visible on pop_data/!empty the cycle after push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clk, rst_n (sync, active-low); push/push_data in; full out;
//        pop in; pop_data/empty/count out.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the write can proceed.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver with majority-vote bit decisions, parity/stop checks and an output FIFO.
// Latency: start edge seen 3 clk after the pin falls; entry visible the cycle after PUSH.
// Backpressure: rx_valid/rx_ready stream; a finished character arriving while the FIFO is full is dropped with an overrun pulse.
// Ports: clk, rst_n (sync, active-low), rx (async line, idle high);
//        rx_data/rx_valid/parity_err/frame_err out, rx_ready in; overrun pulse; fifo_count occupancy.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 19200,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  output logic [DATA_WIDTH-1:0]           rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int      TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int      TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int      PW       = $clog2(OVERSAMPLE);
  localparam int      IW       = $clog2(DATA_WIDTH);
  localparam int      M        = OVERSAMPLE / 2;
  localparam int      FW       = DATA_WIDTH + 2;
  localparam parity_e PAR      = parity_e'(PARITY_MODE[1:0]);

  if (TICK_DIV < 1) begin : g_bad_tick
    $error("uart_rx_ctrl: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("uart_rx_ctrl: DATA_WIDTH must be 5..9");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_ctrl: OVERSAMPLE must be even and >= 8");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_rx_ctrl: PARITY_MODE must be 0..2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_ctrl: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                  sync1_q, sync2_q, prev_q;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic                  tick, fall_edge, resolve, bit_end, bit_val;
  rx_state_e             state_q;
  logic [PW-1:0]         phase_q;
  logic [IW-1:0]         idx_q;
  logic                  stop_q;
  logic [1:0]            smp_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  pe_q, fe_q;
  logic                  push, pop, full, empty;
  logic [FW-1:0]         head;

  // Two-flop synchroniser plus previous value; reset high so a released
  // reset on an idle line never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_edge = prev_q & ~sync2_q;
  assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Restarting on the start edge aligns the sample phases to the frame.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if ((state_q == ST_IDLE && fall_edge) || tick) tick_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  // Majority of samples at phases M-1, M and the live sample at M+1.
  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
  assign resolve = (phase_q == PW'(M + 1));
  assign bit_end = (phase_q == PW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      smp_q   <= 2'b11;
      shift_q <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall_edge) begin
            state_q <= ST_START;
            phase_q <= '0;
          end
        end
        ST_PUSH: begin
          state_q <= ST_IDLE;
          pe_q    <= 1'b0;
          fe_q    <= 1'b0;
        end
        default: begin
          if (tick) begin
            phase_q <= bit_end ? '0 : phase_q + 1'b1;
            if (phase_q == PW'(M - 1)) smp_q[0] <= sync2_q;
            if (phase_q == PW'(M))     smp_q[1] <= sync2_q;
            if (resolve) begin
              case (state_q)
                ST_START:  if (bit_val) state_q <= ST_IDLE;
                ST_DATA:   shift_q[idx_q] <= bit_val;
                ST_PARITY: pe_q <= bit_val ^ (^shift_q) ^ (PAR == ODD);
                ST_STOP: begin
                  if (!bit_val) fe_q <= 1'b1;
                  // Leave mid-bit so a back-to-back start edge is not missed.
                  if (stop_q == 1'(STOP_BITS - 1)) state_q <= ST_PUSH;
                end
                default: ;
              endcase
            end
            if (bit_end) begin
              case (state_q)
                ST_START: begin
                  state_q <= ST_DATA;
                  idx_q   <= '0;
                end
                ST_DATA: begin
                  if (idx_q == IW'(DATA_WIDTH - 1)) begin
                    state_q <= (PAR == NONE) ? ST_STOP : ST_PARITY;
                    stop_q  <= 1'b0;
                  end else begin
                    idx_q <= idx_q + 1'b1;
                  end
                end
                ST_PARITY: begin
                  state_q <= ST_STOP;
                  stop_q  <= 1'b0;
                end
                ST_STOP: stop_q <= 1'b1;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign push = (state_q == ST_PUSH);
  assign pop  = rx_valid & rx_ready;

  uart_rx_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data({pe_q, fe_q, shift_q}),
    .full     (full),
    .pop      (pop),
    .pop_data (head),
    .empty    (empty),
    .count    (fifo_count)
  );

  assign rx_valid   = ~empty;
  assign rx_data    = head[DATA_WIDTH-1:0];
  assign frame_err  = head[DATA_WIDTH];
  assign parity_err = head[DATA_WIDTH+1];
  assign overrun    = push & full & ~pop;

endmodule
